// File: rtl/adder_seq_pkg.sv
// Shared definitions for the board adder operand sequencer:
// FSM state encodings and the default debounce window length.
package adder_seq_pkg;

  // Debounce window for a 50 MHz board clock (10 ms).
  localparam int DEBOUNCE_CYCLES_DEFAULT = 500000;

  // The LED decode uses these exact codes; 2'd3 is never entered legally.
  typedef enum logic [1:0] {
    ST_IDLE_A  = 2'd0,
    ST_WAIT_B  = 2'd1,
    ST_DONE    = 2'd2,
    ST_ILLEGAL = 2'd3
  } seq_state_e;

endpackage

// File: rtl/adder_operand_sequencer_key_debounce.sv
// Load-key conditioner: two-flop synchroniser, debounce counter and a
// one-cycle press strobe on each clean falling edge of the key level.
module key_debounce
  import adder_seq_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEFAULT
) (
  input  logic Clk,
  input  logic reset,
  input  logic key_n,
  output logic press
);

  // A window of one cycle still needs a 1-bit counter to stay legal.
  localparam int CNT_W = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;

  logic             sync1;
  logic             k_s;
  logic             deb;
  logic             deb_d;
  logic [CNT_W-1:0] cnt;

  // Synchronise the raw key and accept a new level only after it has
  // disagreed with the current one for a full window of cycles.
  always_ff @(posedge Clk) begin
    if (reset) begin
      sync1 <= 1'b1;
      k_s   <= 1'b1;
      deb   <= 1'b1;
      deb_d <= 1'b1;
      cnt   <= '0;
    end else begin
      // NOTE: non-blocking assignments let every flop see the pre-edge value
      // of its neighbour, which is what makes sync1 -> k_s a real pipeline.
      sync1 <= key_n;
      k_s   <= sync1;
      deb_d <= deb;
      if (k_s == deb) begin
        cnt <= '0;
      end else if (cnt == CNT_W'(DEBOUNCE_CYCLES - 1)) begin
        deb <= k_s;
        cnt <= '0;
      end else begin
        cnt <= cnt + CNT_W'(1);
      end
    end
  end

  // Falling edge of the debounced level is a press; releases are ignored.
  assign press = deb_d & ~deb;

endmodule

// File: rtl/adder_operand_sequencer.sv
// Operand input stage for the board adder: each clean key press loads the
// switches into A, then B, then starts a new pair. Flags a complete pair with
// a one-cycle sum_valid pulse for the downstream adder/HEX stage.
module adder_operand_sequencer
  import adder_seq_pkg::*;
#(
  parameter int WIDTH           = 8,
  parameter int DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEFAULT
) (
  input  logic             Clk,
  input  logic             reset,
  input  logic [WIDTH-1:0] sw,
  input  logic             key_n,
  output logic [WIDTH-1:0] a,
  output logic [WIDTH-1:0] b,
  output logic             a_valid,
  output logic             b_valid,
  output logic             sum_valid,
  output logic [1:0]       state
);

  logic       press;
  seq_state_e st;

  key_debounce #(
    .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES)
  ) u_deb (
    .Clk   (Clk),
    .reset (reset),
    .key_n (key_n),
    .press (press)
  );

  assign state = st;

  // Operand capture sequence, advancing only on a press strobe.
  always_ff @(posedge Clk) begin
    if (reset) begin
      st        <= ST_IDLE_A;
      a         <= '0;
      b         <= '0;
      a_valid   <= 1'b0;
      b_valid   <= 1'b0;
      sum_valid <= 1'b0;
    end else begin
      // NOTE: sum_valid defaults low each cycle so it can only ever be a
      // single-cycle pulse, set by the B capture below.
      sum_valid <= 1'b0;
      case (st)
        ST_IDLE_A: begin
          if (press) begin
            a       <= sw;
            a_valid <= 1'b1;
            st      <= ST_WAIT_B;
          end
        end
        ST_WAIT_B: begin
          if (press) begin
            b         <= sw;
            b_valid   <= 1'b1;
            sum_valid <= 1'b1;
            st        <= ST_DONE;
          end
        end
        ST_DONE: begin
          // Next press starts a fresh pair; the old B is discarded.
          if (press) begin
            a       <= sw;
            b       <= '0;
            b_valid <= 1'b0;
            st      <= ST_WAIT_B;
          end
        end
        default: begin
          st      <= ST_IDLE_A;
          a       <= '0;
          b       <= '0;
          a_valid <= 1'b0;
          b_valid <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: doc/adder_operand_sequencer.md
Name: adder_operand_sequencer

Overview:
Upstream input stage for the 8-bit board adder. Cleans the raw active-low load key (two-flop synchroniser plus debounce counter) and turns each clean press into one capture event. Successive presses load operand A, then operand B, from the switches. Presents both registered operands plus a one-cycle sum_valid pulse to the adder/HEX decode stage that consumes them.

Parameters:
WIDTH, 8, operand width; equals switch bus width
DEBOUNCE_CYCLES, 500000, consecutive stable cycles required before the debounced key level changes; benches use 4
CNT_W, $clog2(DEBOUNCE_CYCLES), debounce counter width (derived, not overridden)

Ports:
Clk  in  1  single system clock, all state on rising edge
reset  in  1  synchronous, active-high; clears all state at the next rising Clk edge
sw  in  WIDTH  switch value; quasi-static, sampled unsynchronised at capture edges
key_n  in  1  raw load key, active-low (0 = pressed), asynchronous to Clk
a  out  WIDTH  operand A register
b  out  WIDTH  operand B register
a_valid  out  1  high while a holds a captured value
b_valid  out  1  high while b holds a captured value
sum_valid  out  1  one-cycle pulse: a and b both newly valid
state  out  2  FSM state: 0 = IDLE_A, 1 = WAIT_B, 2 = DONE (drives LEDs)

Behaviour:
- Reset (sync, active-high) values: sync flops = 1, debounced level deb = 1, deb_d = 1, cnt = 0, a = 0, b = 0, a_valid = 0, b_valid = 0, sum_valid = 0, state = IDLE_A. Reset has priority over every event, including mid-debounce and mid-sequence.
- Synchroniser: key_n passes through two flops to produce k_s.
- Debounce:
  - If k_s == deb: cnt <= 0.
  - Else if cnt == DEBOUNCE_CYCLES-1: deb <= k_s and cnt <= 0.
  - Else: cnt <= cnt+1.
  - A glitch shorter than DEBOUNCE_CYCLES mismatching cycles never changes deb.
- Press event: press = deb_d & ~deb, where deb_d is deb delayed one cycle. Press is high for exactly one cycle per debounced falling edge.
  - A key released and then held produces nothing further.
  - Release (rising edge) generates no event.
- Latency: key_n sampled low at edge 1 (held stable) gives deb falling at edge N+2 and press high during the following cycle. The FSM captures at edge N+3, where N = DEBOUNCE_CYCLES.
- FSM (transitions only on press):
  - IDLE_A: a <= sw, a_valid <= 1; go to WAIT_B.
  - WAIT_B: b <= sw, b_valid <= 1, sum_valid <= 1 for that one cycle; go to DONE.
  - DONE: a <= sw, b <= 0, b_valid <= 0, a_valid stays 1; go to WAIT_B. This starts a new pair.
  - Encoding 3 is illegal and returns to IDLE_A on the next edge with all registers cleared.
- sum_valid is registered. It is high in exactly the first cycle in which the new b is visible, and low in every other cycle.
- Outputs a and b are held between captures; sw changes have no effect outside capture edges.
- Width rule: a and b are exactly WIDTH bits. No arithmetic is performed here; carry-out belongs to the consumer.

Decomposition:
- Shared header/package adder_seq_pkg: state encodings ST_IDLE_A = 2'd0, ST_WAIT_B = 2'd1, ST_DONE = 2'd2; default DEBOUNCE_CYCLES.
- One sub-module, key_debounce: synchroniser, counter, deb/deb_d, press output; parameterised by DEBOUNCE_CYCLES.
- The FSM and operand registers stay in the top.

Test Plan:
(All scenarios use DEBOUNCE_CYCLES = 4.)
1. Reset held 3 cycles, then released -> a = 0, b = 0, a_valid = 0, b_valid = 0, sum_valid = 0, state = 0; key_n held 1 -> no change for 50 cycles.
2. sw = 8'h3C, key_n low 20 cycles then high -> a = 8'h3C exactly 7 edges after key_n is first sampled low; a_valid = 1; state = 1; single capture despite the long hold.
3. Continue from 2 with sw = 8'hC5, second press -> b = 8'hC5, b_valid = 1, sum_valid high exactly 1 cycle, coincident with b first showing 8'hC5; state = 2.
4. key_n bounce pattern (low 3 cycles, high 1, low 2, high 10) -> no press, a and b unchanged; cnt returns to 0.
5. From DONE, sw = 8'hFF, press -> a = 8'hFF, b = 0, b_valid = 0, a_valid = 1, state = 1, sum_valid stays 0.
6. Reset asserted for 1 cycle while key_n is low and cnt = 2, in WAIT_B -> all outputs at reset values next edge; press completes only after a full fresh debounce window.
